rd_serial_tx: RTL and testbench

Serializer stage that sits directly upstream of the RD receive interface. It plays the RD detector's side of the link: it accepts the trigger forwarded to the RD, then streams one buffer of 24-bit samples over two serial lanes using the RD framing. It is used in-system as the RD emulator for station bring-up and on the bench as the stimulus source for the receiver. Each lane word is 12 data bits MSB first followed by one odd-parity bit, and the whole transfer is framed by ENABLE_XFR.

---
 rtl/rd_serial_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_rd_serial_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_serial_tx.sv
// rtl/rd_serial_tx.sv - RD detector emulator: trigger-framed two-lane serializer with odd parity
//
// Accepts a trigger, waits TRIG_DELAY serial periods, then streams NUM_WORDS
// 24-bit samples from a synchronous-read memory over two serial lanes. Each
// lane word is 12 data bits MSB first plus one odd-parity bit. ENABLE_XFR_OUT
// frames the whole transfer; GAP serial periods follow before re-arming.
//
// Ports:
//   CLK, RST_N            system clock, asynchronous active-low reset
//   TRIG_IN               trigger, rising edge detected
//   RD_ADDR / RD_DATA     sample memory read port (1 CLK read latency)
//   SERIAL_CLK_OUT        free-running CLK/2
//   SERIAL_DATA0/1_OUT    lane 0 ([11:0]) / lane 1 ([23:12]) serial data
//   ENABLE_XFR_OUT        transfer frame
//   BUSY                  high whenever not idle
//   XFR_COUNT             completed transfers (wrapping)
//   TRIG_DROPPED          triggers ignored while busy (saturating)
//   INJECT_LANE/WORD      parity-error injection, only with RD_TX_PARITY_INJECT_EN
//
// Optional feature macro: RD_TX_PARITY_INJECT_EN

module rd_serial_tx #(
    parameter int NUM_WORDS  = 2048,
    parameter int ADDR_W     = 11,
    parameter int TRIG_DELAY = 4,
    parameter int GAP        = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              TRIG_IN,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [23:0]       RD_DATA,
    output logic              SERIAL_CLK_OUT,
    output logic              SERIAL_DATA0_OUT,
    output logic              SERIAL_DATA1_OUT,
    output logic              ENABLE_XFR_OUT,
    output logic              BUSY,
    output logic [15:0]       XFR_COUNT,
    output logic [15:0]       TRIG_DROPPED
`ifdef RD_TX_PARITY_INJECT_EN
    ,
    input  logic [1:0]        INJECT_LANE,
    input  logic [ADDR_W-1:0] INJECT_WORD
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ph;
    logic              r_trig_d;
    logic [7:0]        r_cnt;
    logic [3:0]        r_bit;
    logic [ADDR_W-1:0] r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [11:0]       r_sh0;
    logic [11:0]       r_sh1;
    logic              r_par0;
    logic              r_par1;
    logic              r_sd0;
    logic              r_sd1;
    logic              r_en;
    logic              r_busy;
    logic [15:0]       r_xfr;
    logic [15:0]       r_drop;
`ifdef RD_TX_PARITY_INJECT_EN
    logic [1:0]        r_inj_lane;
    logic [ADDR_W-1:0] r_inj_word;
`endif

    logic              w_fall;
    logic              w_trig_rise;
    logic              w_last_word;
    logic              w_last_addr;
    logic              w_load;
    logic [ADDR_W-1:0] w_lat_word;
    logic              w_inj0;
    logic              w_inj1;
    logic              w_par0;
    logic              w_par1;

    // A fall tick is the edge on which PH goes 1->0, so PH==1 before it.
    assign w_fall      = r_ph;
    assign w_trig_rise = TRIG_IN & ~r_trig_d;
    assign w_last_word = (r_word == ADDR_W'(NUM_WORDS - 1));
    assign w_last_addr = (r_addr == ADDR_W'(NUM_WORDS - 1));

    // Fall ticks that put bit 11 of a new word on the lanes and latch RD_DATA.
    assign w_load = w_fall &&
                    (((r_state == S_WAIT) && (r_cnt == 8'd1)) ||
                     ((r_state == S_SHIFT) && (r_bit == 4'd12) && !w_last_word));

    // Index of the word being latched on a load tick.
    assign w_lat_word = (r_state == S_WAIT) ? '0 : r_word + 1'b1;

`ifdef RD_TX_PARITY_INJECT_EN
    assign w_inj0 = r_inj_lane[0] && (w_lat_word == r_inj_word);
    assign w_inj1 = r_inj_lane[1] && (w_lat_word == r_inj_word);
`else
    assign w_inj0 = 1'b0;
    assign w_inj1 = 1'b0;
`endif

    assign w_par0 = (~^RD_DATA[11:0])  ^ w_inj0;
    assign w_par1 = (~^RD_DATA[23:12]) ^ w_inj1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_ph     <= 1'b0;
            r_trig_d <= 1'b0;
            r_cnt    <= 8'd0;
            r_bit    <= 4'd0;
            r_word   <= '0;
            r_addr   <= '0;
            r_sh0    <= 12'd0;
            r_sh1    <= 12'd0;
            r_par0   <= 1'b0;
            r_par1   <= 1'b0;
            r_sd0    <= 1'b0;
            r_sd1    <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_xfr    <= 16'd0;
            r_drop   <= 16'd0;
`ifdef RD_TX_PARITY_INJECT_EN
            r_inj_lane <= 2'b00;
            r_inj_word <= '0;
`endif
        end else begin
            r_ph     <= ~r_ph;
            r_trig_d <= TRIG_IN;

            // The GAP->IDLE edge still sees r_state==S_GAP, so it counts as dropped.
            if (w_trig_rise && (r_state != S_IDLE) && (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_trig_rise) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'(TRIG_DELAY);
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
`ifdef RD_TX_PARITY_INJECT_EN
                        r_inj_lane <= INJECT_LANE;
                        r_inj_word <= INJECT_WORD;
`endif
                    end
                end
                S_WAIT: begin
                    if (w_fall) begin
                        if (r_cnt == 8'd1) begin
                            r_state <= S_SHIFT;
                            r_en    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        if (r_bit == 4'd12) begin
                            if (w_last_word) begin
                                r_state <= S_GAP;
                                r_cnt   <= 8'(GAP);
                                r_en    <= 1'b0;
                                r_sd0   <= 1'b0;
                                r_sd1   <= 1'b0;
                                r_xfr   <= r_xfr + 16'd1;
                            end
                        end else if (r_bit == 4'd11) begin
                            r_bit <= 4'd12;
                            r_sd0 <= r_par0;
                            r_sd1 <= r_par1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                            r_sd0 <= r_sh0[11];
                            r_sd1 <= r_sh1[11];
                            r_sh0 <= {r_sh0[10:0], 1'b0};
                            r_sh1 <= {r_sh1[10:0], 1'b0};
                        end
                    end
                end
                S_GAP: begin
                    if (w_fall) begin
                        if (r_cnt == 8'd1) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Word load: bit 11 goes out now, remaining bits wait in the shifters.
            if (w_load) begin
                r_word <= w_lat_word;
                r_bit  <= 4'd0;
                r_sd0  <= RD_DATA[11];
                r_sd1  <= RD_DATA[23];
                r_sh0  <= {RD_DATA[10:0], 1'b0};
                r_sh1  <= {RD_DATA[22:12], 1'b0};
                r_par0 <= w_par0;
                r_par1 <= w_par1;
                r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign RD_ADDR          = r_addr;
    assign SERIAL_CLK_OUT   = r_ph;
    assign SERIAL_DATA0_OUT = r_sd0;
    assign SERIAL_DATA1_OUT = r_sd1;
    assign ENABLE_XFR_OUT   = r_en;
    assign BUSY             = r_busy;
    assign XFR_COUNT        = r_xfr;
    assign TRIG_DROPPED     = r_drop;

endmodule

// File: tb/tb_rd_serial_tx.sv
// tb/tb_rd_serial_tx.sv - scoreboard bench for rd_serial_tx (NUM_WORDS=4, TRIG_DELAY=3, GAP=2)

module tb_rd_serial_tx;

    localparam int NW = 4;
    localparam int AW = 11;
    localparam int TD = 3;
    localparam int GP = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          TRIG_IN = 1'b0;
    logic [AW-1:0] RD_ADDR;
    logic [23:0]   RD_DATA = 24'd0;
    logic          SERIAL_CLK_OUT;
    logic          SERIAL_DATA0_OUT;
    logic          SERIAL_DATA1_OUT;
    logic          ENABLE_XFR_OUT;
    logic          BUSY;
    logic [15:0]   XFR_COUNT;
    logic [15:0]   TRIG_DROPPED;
`ifdef RD_TX_PARITY_INJECT_EN
    logic [1:0]    INJECT_LANE = 2'b00;
    logic [AW-1:0] INJECT_WORD = '0;
`endif

    int          n_checks = 0;
    int          n_errs   = 0;
    int          mode     = 0;
    logic [1:0]  inj_lane = 2'b00;
    int          inj_word = 0;
    logic [25:0] exp_q[$];
    int          exp_xfr  = 0;
    int          exp_drop = 0;

    rd_serial_tx #(
        .NUM_WORDS (NW),
        .ADDR_W    (AW),
        .TRIG_DELAY(TD),
        .GAP       (GP)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .TRIG_IN         (TRIG_IN),
        .RD_ADDR         (RD_ADDR),
        .RD_DATA         (RD_DATA),
        .SERIAL_CLK_OUT  (SERIAL_CLK_OUT),
        .SERIAL_DATA0_OUT(SERIAL_DATA0_OUT),
        .SERIAL_DATA1_OUT(SERIAL_DATA1_OUT),
        .ENABLE_XFR_OUT  (ENABLE_XFR_OUT),
        .BUSY            (BUSY),
        .XFR_COUNT       (XFR_COUNT),
        .TRIG_DROPPED    (TRIG_DROPPED)
`ifdef RD_TX_PARITY_INJECT_EN
        ,
        .INJECT_LANE     (INJECT_LANE),
        .INJECT_WORD     (INJECT_WORD)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [23:0] mem_word(input int a);
        case (mode)
            1:       return 24'h000000;
            2:       return 24'hFFFFFF;
            default: return {12'hA00 + 12'(a), 12'hF00 + 12'(a)};
        endcase
    endfunction

    // Synchronous-read sample memory, one CLK latency.
    always @(posedge CLK) RD_DATA <= mem_word(int'(RD_ADDR));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_frame();
        logic [23:0] d;
        logic        p0;
        logic        p1;
        for (int w = 0; w < NW; w++) begin
            d  = mem_word(w);
            p0 = ~^d[11:0];
            p1 = ~^d[23:12];
            if (w == inj_word) begin
                p0 = p0 ^ inj_lane[0];
                p1 = p1 ^ inj_lane[1];
            end
            exp_q.push_back({d[11:0], p0, d[23:12], p1});
        end
    endtask

    // Monitor: collect one bit per lane on each SERIAL_CLK_OUT rise inside the frame.
    int          mon_bits  = 0;
    int          mon_rises = 0;
    logic        prev_sck  = 1'b0;
    logic        prev_en   = 1'b0;
    logic [12:0] sh0 = '0;
    logic [12:0] sh1 = '0;
    logic [25:0] exp_w;

    always @(negedge CLK) begin
        if (!RST_N) begin
            mon_bits  = 0;
            mon_rises = 0;
            prev_sck  = 1'b0;
            prev_en   = 1'b0;
        end else begin
            if (SERIAL_CLK_OUT && !prev_sck && ENABLE_XFR_OUT) begin
                sh0 = {sh0[11:0], SERIAL_DATA0_OUT};
                sh1 = {sh1[11:0], SERIAL_DATA1_OUT};
                mon_bits++;
                mon_rises++;
                if (mon_bits == 13) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("lane0_word", 32'(sh0), 32'(exp_w[25:13]));
                        check("lane1_word", 32'(sh1), 32'(exp_w[12:0]));
                    end
                end
            end
            if (prev_en && !ENABLE_XFR_OUT) begin
                check("frame_len", 32'(mon_rises), 32'(13 * NW));
                check("frame_partial_bits", 32'(mon_bits), 32'd0);
                mon_rises = 0;
            end
            prev_sck = SERIAL_CLK_OUT;
            prev_en  = ENABLE_XFR_OUT;
        end
    end

    task automatic pulse_trig();
        @(posedge CLK); #1 TRIG_IN = 1'b1;
        @(posedge CLK); #1 TRIG_IN = 1'b0;
    endtask

    task automatic fire(input bit timed);
        int n;
        pulse_trig();
        if (timed) begin
            check("busy_after_1clk", 32'(BUSY), 32'd1);
            n = 1;
            while (!ENABLE_XFR_OUT && n < 40) begin
                @(posedge CLK); #1;
                n++;
            end
            check("en_rise_6or7", 32'(n == 6 || n == 7), 32'd1);
        end
    endtask

    task automatic wait_en_rise();
        int n = 0;
        while (!ENABLE_XFR_OUT && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("en_rise_timeout", 32'(ENABLE_XFR_OUT), 32'd1);
    endtask

    task automatic wait_idle(input bit timed);
        int n = 0;
        int m = 0;
        if (timed) begin
            while (ENABLE_XFR_OUT && n < 500) begin
                @(posedge CLK); #1;
                n++;
            end
            check("en_fall_timeout", 32'(ENABLE_XFR_OUT), 32'd0);
            while (BUSY && m < 40) begin
                @(posedge CLK); #1;
                m++;
            end
            check("busy_fall_4or5", 32'(m == 4 || m == 5), 32'd1);
        end
        n = 0;
        while (BUSY && n < 2000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("idle_timeout", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_serial_outs", {27'd0, SERIAL_CLK_OUT, SERIAL_DATA0_OUT, SERIAL_DATA1_OUT,
                                  ENABLE_XFR_OUT, BUSY}, 32'd0);
        check("rst_rd_addr", 32'(RD_ADDR), 32'd0);
        check("rst_xfr_count", 32'(XFR_COUNT), 32'd0);
        check("rst_trig_dropped", 32'(TRIG_DROPPED), 32'd0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Single frame with timing checks.
        mode = 0;
        push_frame();
        fire(1'b1);
        wait_idle(1'b1);
        exp_xfr++;
        check("xfr_count_1", 32'(XFR_COUNT), 32'(exp_xfr));

        // Trigger during word 2 is dropped.
        push_frame();
        fire(1'b0);
        wait_en_rise();
        repeat (54) @(posedge CLK);
        #1;
        pulse_trig();
        exp_drop++;
        check("trig_dropped", 32'(TRIG_DROPPED), 32'(exp_drop));
        wait_idle(1'b0);
        exp_xfr++;
        check("xfr_count_after_drop", 32'(XFR_COUNT), 32'(exp_xfr));

        // Trigger after gap is accepted.
        push_frame();
        fire(1'b0);
        wait_idle(1'b0);
        exp_xfr++;
        check("xfr_count_after_gap", 32'(XFR_COUNT), 32'(exp_xfr));

        // All-zero and all-one data.
        for (int md = 1; md <= 2; md++) begin
            mode = md;
            repeat (2) @(posedge CLK);
            push_frame();
            fire(1'b0);
            wait_idle(1'b0);
            exp_xfr++;
            check("xfr_count_data", 32'(XFR_COUNT), 32'(exp_xfr));
        end

`ifdef RD_TX_PARITY_INJECT_EN
        mode        = 0;
        inj_lane    = 2'b10;
        inj_word    = 2;
        INJECT_LANE = 2'b10;
        INJECT_WORD = AW'(2);
        repeat (2) @(posedge CLK);
        push_frame();
        fire(1'b0);
        INJECT_LANE = 2'b00;
        INJECT_WORD = '0;
        inj_lane    = 2'b00;
        inj_word    = 0;
        wait_idle(1'b0);
        exp_xfr++;
        check("xfr_count_inject", 32'(XFR_COUNT), 32'(exp_xfr));
`endif

        check("drop_stable", 32'(TRIG_DROPPED), 32'(exp_drop));

        // Reset mid-frame (around word 1 bit 5).
        mode = 0;
        repeat (2) @(posedge CLK);
        push_frame();
        fire(1'b0);
        wait_en_rise();
        repeat (38) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        check("midrst_serial_outs", {27'd0, SERIAL_CLK_OUT, SERIAL_DATA0_OUT, SERIAL_DATA1_OUT,
                                     ENABLE_XFR_OUT, BUSY}, 32'd0);
        check("midrst_rd_addr", 32'(RD_ADDR), 32'd0);
        check("midrst_counts", {XFR_COUNT, TRIG_DROPPED}, 32'd0);
        exp_q.delete();
        exp_xfr  = 0;
        exp_drop = 0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        check("ph_restart", 32'(SERIAL_CLK_OUT), 32'd0);
        push_frame();
        fire(1'b0);
        wait_idle(1'b0);
        exp_xfr++;
        check("xfr_count_after_rst", 32'(XFR_COUNT), 32'(exp_xfr));

        repeat (10) @(posedge CLK);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
